ps2_key_capture: RTL

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and tracks which key is held. It outputs the scan code of the currently held key, or 0x00 when no key is held. This code drives the note-lookup stage's live-key input, so a released key maps to silence there. It also emits a one-cycle strobe per received byte for the recorder/playback logic.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_frame_rx.sv | 113 +++++++++++
 rtl/ps2_key_capture.sv | 66 ++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame-receiver state type for the PS/2 key capture block.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock-fall detect, 11-bit frame FSM
// with odd-parity check and an inter-bit watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_bit;

  rx_state_t  state, state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift, shift_next;
  logic       parity, parity_next;
  logic       err_next;
  logic       timeout;
  logic [WD_W-1:0] wd;

  // Synchronizer and fall-detect stage; idle-high reset avoids a false fall
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit = data_sync[SYNC_STAGES-1];
  assign timeout  = (state != ST_IDLE) && (wd == WD_LAST);

  // byte_valid is combinational so the top can register byte, key and strobe
  // on the same edge that frame_err is registered here.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    parity_next  = parity;
    byte_valid   = 1'b0;
    err_next     = 1'b0;
    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_bit) begin
            bit_cnt_next = 3'd0;
            state_next   = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_next   = {data_bit, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
          parity_next = data_bit;
          state_next  = ST_STOP;
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          if (data_bit && (^{shift, parity})) byte_valid = 1'b1;
          else                                err_next   = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      wd        <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      frame_err <= err_next;
      if (fall || state == ST_IDLE) wd <= '0;
      else                          wd <= wd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift  <= shift_next;
    parity <= parity_next;
  end

  assign byte_data = shift;

endmodule

// File: rtl/ps2_key_capture.sv
// PS/2 keyboard capture: tracks the currently held make code (0x00 when none)
// and strobes every valid received byte.
module ps2_key_capture
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic [7:0] code,
  output logic       code_strobe,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       brk;
  logic       ext;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Extended sequences are swallowed whole; a break only clears a matching key
  always_ff @(posedge clk) begin
    if (rst) begin
      key         <= 8'h00;
      code        <= 8'h00;
      code_strobe <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
    end else begin
      code_strobe <= byte_valid;
      if (byte_valid) begin
        code <= byte_data;
        if (byte_data == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (byte_data == PS2_EXT) begin
          ext <= 1'b1;
        end else if (ext) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else if (brk) begin
          if (byte_data == key) key <= 8'h00;
          brk <= 1'b0;
        end else begin
          key <= byte_data;
        end
      end
    end
  end

endmodule
